// File: rtl/i2c_target_if.sv
`timescale 1ns/1ps
// i2c_target_if: pad and memory-port bundle between the I2C target and its surroundings.
// Strobe semantics (no backpressure on this port): mem_we and mem_re are single-cycle
// strobes that are always accepted; mem_addr/mem_wdata are valid in the strobe cycle,
// and mem_rdata must be valid on the cycle after mem_re. sda_oe=1 pulls the open-drain
// SDA pad low, sda_oe=0 releases it.
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic [3:0] dbg_state;

  modport slave (
    input  scl_in, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy, dbg_state
  );

  modport master (
    output scl_in, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy, dbg_state
  );
endinterface

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: oversampled byte-oriented I2C target answering DEV_ADDR, with an 8-bit
// auto-incrementing pointer into a 256-byte synchronous memory port.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        reset_n,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_WR_PTR     = 4'd3,
    ST_WR_PTR_ACK = 4'd4,
    ST_WR_DATA    = 4'd5,
    ST_WR_ACK     = 4'd6,
    ST_RD_LOAD    = 4'd7,
    ST_RD_DATA    = 4'd8,
    ST_RD_ACK     = 4'd9,
    ST_IGNORE     = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic [7:0] r_wdata;
  logic       r_rw;
  logic       r_mack;
  logic       r_we;
  logic       r_busy;
  logic       w_sda_oe;
  logic       w_mem_re;

  // Two-flop synchronizers plus a history flop; idle bus level is high so reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl_in; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= bus.sda_in; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
  assign w_start     = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop      = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic; START/STOP override any bit-level progress.
  always_comb begin
    w_next_state = r_state;
    if (w_start) begin
      w_next_state = ST_ADDR;
    end else if (w_stop) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR:       if (w_byte_done)
                         w_next_state = (r_shift[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:   if (w_scl_fall) w_next_state = r_rw ? ST_RD_LOAD : ST_WR_PTR;
        ST_WR_PTR:     if (w_byte_done) w_next_state = ST_WR_PTR_ACK;
        ST_WR_PTR_ACK: if (w_scl_fall) w_next_state = ST_WR_DATA;
        ST_WR_DATA:    if (w_byte_done) w_next_state = ST_WR_ACK;
        ST_WR_ACK:     if (w_scl_fall) w_next_state = ST_WR_DATA;
        ST_RD_LOAD:    if (r_bit_cnt != 4'd0) w_next_state = ST_RD_DATA;
        ST_RD_DATA:    if (w_byte_done) w_next_state = ST_RD_ACK;
        ST_RD_ACK:     if (w_scl_fall) w_next_state = r_mack ? ST_IGNORE : ST_RD_LOAD;
        default:       w_next_state = r_state;
      endcase
    end
  end

  // Outputs decoded from state: drive only in ACK slots and for zero read bits.
  always_comb begin
    w_sda_oe = 1'b0;
    w_mem_re = 1'b0;
    case (r_state)
      ST_ADDR_ACK, ST_WR_PTR_ACK, ST_WR_ACK: w_sda_oe = 1'b1;
      ST_RD_DATA: w_sda_oe = ~r_shift[7];
      ST_RD_LOAD: w_mem_re = (r_bit_cnt == 4'd0);
      default: w_sda_oe = 1'b0;
    endcase
  end

  // Datapath: bit counter, shift register, pointer, write strobe and busy flag.
  // RD_LOAD uses the bit counter as a two-cycle phase: strobe, then capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_ptr     <= 8'h00;
      r_wdata   <= 8'h00;
      r_rw      <= 1'b0;
      r_mack    <= 1'b1;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_ptr <= r_ptr + 8'd1;
      if (w_next_state == ST_ADDR_ACK)  r_busy <= 1'b1;
      else if (w_next_state == ST_IDLE) r_busy <= 1'b0;
      if (w_start || w_stop) begin
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_byte_done) begin
              r_bit_cnt <= 4'd0;
              if (r_state == ST_ADDR)    r_rw  <= r_shift[0];
              if (r_state == ST_WR_PTR)  r_ptr <= r_shift;
              if (r_state == ST_WR_DATA) begin
                r_we    <= 1'b1;
                r_wdata <= r_shift;
              end
            end
          end
          ST_RD_LOAD: begin
            if (r_bit_cnt == 4'd0) begin
              r_bit_cnt <= 4'd1;
            end else begin
              r_shift   <= bus.mem_rdata;
              r_ptr     <= r_ptr + 8'd1;
              r_bit_cnt <= 4'd0;
            end
          end
          ST_RD_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              r_shift <= {r_shift[6:0], 1'b0};
              if (r_bit_cnt == 4'd8) r_bit_cnt <= 4'd0;
            end
          end
          ST_RD_ACK: if (w_scl_rise) r_mack <= r_sda_s2;
          default: r_bit_cnt <= r_bit_cnt;
        endcase
      end
    end
  end

  assign bus.sda_oe    = w_sda_oe;
  assign bus.mem_re    = w_mem_re;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_ptr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// tb_i2c_target: directed plus randomized bus transactions against a byte-level
// memory/pointer reference model, with a scoreboard of expected memory strobes.
module tb_i2c_target;
  localparam int Q = 100;  // quarter SCL period in ns (10 system clocks)

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  i2c_target_if bus_if();
  i2c_target #(.DEV_ADDR(7'h50)) dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));

  // clock / reset block
  always #5 clk = ~clk;

  assign bus_if.scl_in = m_scl;
  assign bus_if.sda_in = m_sda & ~bus_if.sda_oe;  // open-drain wired-AND

  // storage array attached to the memory port
  logic [7:0] seed_mem [256];
  logic [7:0] stor [256];
  logic [7:0] rdata_r = 8'h00;
  logic       init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) stor[i] <= seed_mem[i];
      init_done <= 1'b1;
    end else if (bus_if.mem_we) begin
      stor[bus_if.mem_addr] <= bus_if.mem_wdata;
    end
    if (bus_if.mem_re) rdata_r <= stor[bus_if.mem_addr];
  end
  assign bus_if.mem_rdata = rdata_r;

  // monitor, sampled on the falling clock edge
  logic [7:0] obs_wa[$], obs_wd[$], obs_ra[$];
  int oe_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (bus_if.mem_we) begin
      obs_wa.push_back(bus_if.mem_addr);
      obs_wd.push_back(bus_if.mem_wdata);
    end
    if (bus_if.mem_re) obs_ra.push_back(bus_if.mem_addr);
    if (bus_if.sda_oe) oe_cnt++;
    if (bus_if.busy) busy_cnt++;
  end

  // reference model and expected queues
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr;
  logic [7:0] exp_wa[$], exp_wd[$], exp_ra[$];
  int wbase = 0;
  int rbase = 0;
  logic [7:0] wbuf [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    int nw;
    int nr;
    nw = obs_wa.size() - wbase;
    nr = obs_ra.size() - rbase;
    check({tag, " wr_count"}, nw, exp_wa.size());
    for (int i = 0; i < nw && i < exp_wa.size(); i++) begin
      check({tag, " wr_addr"}, obs_wa[wbase + i], exp_wa[i]);
      check({tag, " wr_data"}, obs_wd[wbase + i], exp_wd[i]);
    end
    check({tag, " rd_count"}, nr, exp_ra.size());
    for (int i = 0; i < nr && i < exp_ra.size(); i++)
      check({tag, " rd_addr"}, obs_ra[rbase + i], exp_ra[i]);
    wbase = obs_wa.size();
    rbase = obs_ra.size();
    exp_wa.delete();
    exp_wd.delete();
    exp_ra.delete();
  endtask

  // driver tasks: bus-level master
  task automatic bus_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = bus_if.sda_in; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  // transaction-level tasks, each updating the reference model
  task automatic txn_write(input logic [7:0] ptr, input int n);
    logic ack;
    bus_start();
    put_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_busy", bus_if.busy, 1'b1);
    put_byte(ptr, ack);
    check("wr_ptr_ack", ack, 1'b0);
    ref_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], ack);
      check("wr_data_ack", ack, 1'b0);
      exp_wa.push_back(ref_ptr);
      exp_wd.push_back(wbuf[i]);
      ref_mem[ref_ptr] = wbuf[i];
      ref_ptr = ref_ptr + 8'd1;
    end
    bus_stop();
    check("wr_ptr_after", bus_if.mem_addr, ref_ptr);
    check("wr_busy_idle", bus_if.busy, 1'b0);
    check_sb("wr");
  endtask

  task automatic txn_read(input logic rnd, input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (rnd) begin
      put_byte(8'hA0, ack);
      check("rd_waddr_ack", ack, 1'b0);
      put_byte(ptr, ack);
      check("rd_ptr_ack", ack, 1'b0);
      ref_ptr = ptr;
      bus_start();
    end
    put_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      get_byte(d, (i == n - 1));
      check("rd_data", d, ref_mem[ref_ptr]);
      exp_ra.push_back(ref_ptr);
      ref_ptr = ref_ptr + 8'd1;
    end
    check("rd_release", bus_if.sda_oe, 1'b0);
    bus_stop();
    check("rd_ptr_after", bus_if.mem_addr, ref_ptr);
    check("rd_busy_idle", bus_if.busy, 1'b0);
    check_sb("rd");
  endtask

  task automatic txn_foreign(input logic [6:0] a, input logic rw, input logic [7:0] d);
    logic ack;
    int oe0;
    int b0;
    oe0 = oe_cnt;
    b0 = busy_cnt;
    bus_start();
    put_byte({a, rw}, ack);
    check("nm_addr_nack", ack, 1'b1);
    put_byte(d, ack);
    check("nm_data_nack", ack, 1'b1);
    bus_stop();
    check("nm_oe_cycles", oe_cnt - oe0, 0);
    check("nm_busy_cycles", busy_cnt - b0, 0);
    check("nm_ptr", bus_if.mem_addr, ref_ptr);
    check_sb("nm");
  endtask

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack;
    logic b;
    int op;
    int n;
    logic [7:0] p;
    logic [6:0] fa;

    for (int i = 0; i < 256; i++) begin
      seed_mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i]  = seed_mem[i];
    end
    ref_ptr = 8'h00;

    // reset state
    #(3*Q);
    check("rst_sda_oe", bus_if.sda_oe, 1'b0);
    check("rst_mem_we", bus_if.mem_we, 1'b0);
    check("rst_mem_re", bus_if.mem_re, 1'b0);
    check("rst_mem_addr", bus_if.mem_addr, 8'h00);
    check("rst_mem_wdata", bus_if.mem_wdata, 8'h00);
    check("rst_busy", bus_if.busy, 1'b0);
    reset_n = 1'b1;
    #Q;

    // pointer + sequential write
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    txn_write(8'h10, 2);

    // random read with repeated START, ACK then NACK
    txn_read(1'b1, 8'h20, 2);

    // foreign address 0x51 (byte 0xA2)
    txn_foreign(7'h51, 1'b0, 8'h55);

    // pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    txn_write(8'hFF, 2);

    // STOP after 3 data bits: no write, back to idle, next transaction acknowledged
    bus_start();
    put_byte(8'hA0, ack);
    check("sm_addr_ack", ack, 1'b0);
    put_byte(8'h60, ack);
    check("sm_ptr_ack", ack, 1'b0);
    ref_ptr = 8'h60;
    for (int i = 0; i < 3; i++) put_bit(1'($urandom_range(0, 1)));
    bus_stop();
    check("sm_busy", bus_if.busy, 1'b0);
    check("sm_ptr", bus_if.mem_addr, 8'h60);
    check_sb("sm");
    txn_read(1'b0, 8'h00, 1);

    // reset during the 4th bit of a read byte whose bits are all zero
    wbuf[0] = 8'h00;
    txn_write(8'h40, 1);
    bus_start();
    put_byte(8'hA0, ack);
    put_byte(8'h40, ack);
    bus_start();
    put_byte(8'hA1, ack);
    check("rr_addr_ack", ack, 1'b0);
    exp_ra.push_back(8'h40);
    for (int i = 0; i < 3; i++) get_bit(b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
    check("rr_driving", bus_if.sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rr_sda_oe", bus_if.sda_oe, 1'b0);
    check("rr_busy", bus_if.busy, 1'b0);
    check("rr_mem_addr", bus_if.mem_addr, 8'h00);
    ref_ptr = 8'h00;
    #(Q - 1);
    reset_n = 1'b1;
    #Q; m_scl = 1'b0; #Q;
    check_sb("rr");
    wbuf[0] = 8'($urandom_range(0, 255));
    txn_write(8'h05, 1);

    // randomized transactions
    for (int it = 0; it < 10; it++) begin
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 4);
      p  = 8'($urandom_range(0, 255));
      case (op)
        0: begin
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
          txn_write(p, n);
        end
        1: txn_read(1'b1, p, n);
        2: txn_read(1'b0, p, n);
        default: begin
          fa = 7'($urandom_range(0, 127));
          if (fa == 7'h50) fa = 7'h2C;
          txn_foreign(fa, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

Byte-oriented I2C target (slave) that answers a single 7-bit device address and exposes a 256-byte register/memory space through a simple synchronous memory port. It is the responder counterpart of the team's `i2c_master`, and sits between the open-drain SCL/SDA pads and the EEPROM storage array. SCL and SDA are oversampled on the system clock. The block supports pointer write, sequential write, current-address read, sequential read and repeated START.

## Interface
Parameters:
- `DEV_ADDR`, 7'h50: 7-bit device address the block acknowledges.

Ports:
- `clk`, in, 1: system clock. Must be at least 16× the SCL frequency.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `scl_in`, in, 1: SCL pad input. Asynchronous.
- `sda_in`, in, 1: SDA pad input. Asynchronous.
- `sda_oe`, out, 1: 1 pulls SDA low; 0 releases it. The pad is open-drain, `sda = sda_oe ? 0 : z`.
- `mem_addr`, out, 8: memory address, equal to the current pointer.
- `mem_wdata`, out, 8: write data.
- `mem_we`, out, 1: one-cycle write strobe.
- `mem_re`, out, 1: one-cycle read strobe.
- `mem_rdata`, in, 8: read data, valid on the cycle after `mem_re`.
- `busy`, out, 1: high from an addressed START until STOP/IDLE.

## Operation
- Input conditioning: `scl_in` and `sda_in` each pass through a 2-flop synchronizer plus one history flop. Edges are detected on the synchronized values only.
- START = synced SDA falls while synced SCL is high. STOP = synced SDA rises while synced SCL is high.
  - START in any state clears the bit counter and enters ADDR.
  - STOP in any state enters IDLE and releases `sda_oe`.
  - START/STOP take priority over bit handling in the same cycle.
- Data bits are sampled on synced SCL rising edges, MSB first. `sda_oe` changes only on the cycle after a synced SCL falling edge.
- States and transitions:
  - IDLE: `sda_oe` = 0. On START go to ADDR.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - Address matches `DEV_ADDR`: go to ADDR_ACK.
    - No match: go to IGNORE.
  - ADDR_ACK: drive ACK (`sda_oe` = 1) for one SCL low+high period. On the following SCL fall, branch on R/W:
    - W: first byte is the pointer, go to WR_PTR.
    - R: go to RD_LOAD.
  - WR_PTR: receive 8 bits, then WR_PTR_ACK. Drive ACK and load pointer = byte, then go to WR_DATA.
  - WR_DATA: receive 8 bits, then WR_ACK. Drive ACK, pulse `mem_we` exactly once with `mem_addr` = pointer and `mem_wdata` = byte, increment the pointer, then return to WR_DATA.
  - RD_LOAD: pulse `mem_re` with `mem_addr` = pointer, capture `mem_rdata` next cycle into the shift register, increment the pointer, then go to RD_DATA.
  - RD_DATA: drive 8 bits; bit value 0 → `sda_oe` = 1. After the 8th bit, go to RD_ACK.
  - RD_ACK: release SDA and sample the master bit on the SCL rise.
    - ACK (0): go to RD_LOAD.
    - NACK (1): go to IGNORE.
  - IGNORE: never drives. Waits for START or STOP.
- Pointer: 8 bits, retained across STOP and repeated START, wraps 8'hFF → 8'h00. Reset value 0.
- Current-address read (R directly after ADDR_ACK) reads from the retained pointer.
- Master-driven SDA is never overridden. The block drives only during its ACK slots and read-data slots.

## Timing
- Reset values: `sda_oe` 0, `mem_we` 0, `mem_re` 0, `mem_addr` 8'h00, `mem_wdata` 8'h00, `busy` 0, state IDLE, pointer 8'h00.
- Input-to-detect latency: 2 clocks (synchronizer) + 1 clock (edge flop).
- `sda_oe` update: 1 clock after the detected SCL fall. This provides hold margin of at least 3 clocks after the pad edge.
- `mem_we`: asserted for exactly 1 clock during the ACK low phase following the 8th data bit.
- Read path: `mem_re` is asserted on the clock after the SCL fall that ends ADDR_ACK or RD_ACK. Data is loaded 1 clock later, which is before the next SCL rise given the 16× clock ratio.
- `reset_n` low mid-transfer: all outputs return immediately (asynchronously) to their reset values. After release, the block ignores bus activity until the next START.
- `busy` rises on the cycle ADDR_ACK is entered and falls on the cycle IDLE is entered.

## Test plan
- Write: START, addr 0xA0, 0x10, 0xA5, 0x3C, STOP → ACK on all four bytes; `mem_we` at 0x10 = 0xA5 and at 0x11 = 0x3C; pointer = 0x12.
- Random read: START, 0xA0, 0x20, repeated START, 0xA1, master ACK, then NACK → `mem_re` at 0x20 and 0x21; bytes on SDA equal the memory model contents; SDA released after the NACK; no `mem_we`.
- Address mismatch: START, 0xA2, 0x55, STOP → `sda_oe` never asserted; no `mem_we`/`mem_re`; `busy` stays 0.
- Wrap: pointer 0xFF, write 0x11, 0x22 → writes at 0xFF then 0x00.
- Reset mid-transfer: `reset_n` low during the 4th bit of a read byte → `sda_oe` is 0 immediately. A subsequent write with pointer 0x05 → write at 0x05 succeeds.
- STOP mid-byte: STOP after 3 data bits in WR_DATA → no `mem_we`; state is IDLE; the next transaction is ACKed normally.
